// File: rtl/decode_wb.sv
// Decode / memory / write-back sequencer with a 32x8 register file for a multi-cycle core.
// Optional `SINGLE_STEP_EN adds a step input that gates each instruction fetch.
module decode_wb #(
  parameter int unsigned MAX_PC     = 14,
  parameter int unsigned OUTPUT_REG = 2
) (
  input  logic        clk,
  input  logic        rst,
`ifdef SINGLE_STEP_EN
  input  logic        step,
`endif
  input  logic [7:0]  pc_in,
  input  logic [7:0]  result_in,
  input  logic        invalid_in,
  output logic [7:0]  instr_addr,
  input  logic [31:0] instr_data,
  output logic [7:0]  dmem_addr,
  input  logic [7:0]  dmem_data,
  output logic [2:0]  state,
  output logic [5:0]  opcode,
  output logic [5:0]  func,
  output logic [15:0] imm,
  output logic [25:0] jt,
  output logic [7:0]  rsv,
  output logic [7:0]  rtv,
  output logic [7:0]  out_value,
  output logic        halted
);

  localparam int unsigned DW    = 8;
  localparam int unsigned IW    = 32;
  localparam int unsigned RW    = 5;
  localparam int unsigned NREGS = 32;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_DECODE  = 3'd2;
  localparam logic [2:0] S_EXECUTE = 3'd3;
  localparam logic [2:0] S_WAIT    = 3'd4;
  localparam logic [2:0] S_MEM     = 3'd5;
  localparam logic [2:0] S_WB      = 3'd6;
  localparam logic [2:0] S_HALT    = 3'd7;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SLT   = 6'h2a;

  localparam logic [RW-1:0] RA_IDX   = RW'(31);
  localparam logic [RW-1:0] OUT_IDX  = RW'(OUTPUT_REG);
  localparam logic [DW-1:0] MAX_PC_V = DW'(MAX_PC);

  logic [2:0]                  state_q, state_d;
  logic [IW-1:0]               ir_q, ir_d;
  logic [DW-1:0]               rsv_q, rsv_d;
  logic [DW-1:0]               rtv_q, rtv_d;
  logic [DW-1:0]               dmem_addr_q, dmem_addr_d;
  logic                        halted_q, halted_d;
  logic [NREGS-1:0][DW-1:0]    regs_q, regs_d;

  logic                        fetch_go;
  logic                        wr_en;
  logic [RW-1:0]               wr_idx;
  logic [DW-1:0]               wr_data;
  logic [RW-1:0]               rs_idx, rt_idx, rd_idx;
  logic [DW-1:0]               rs_val, rt_val;

`ifdef SINGLE_STEP_EN
  assign fetch_go = step;
`else
  assign fetch_go = 1'b1;
`endif

  assign rs_idx = ir_q[25:21];
  assign rt_idx = ir_q[20:16];
  assign rd_idx = ir_q[15:11];

  // Register 0 reads as zero regardless of storage contents.
  assign rs_val = (rs_idx == '0) ? '0 : regs_q[rs_idx];
  assign rt_val = (rt_idx == '0) ? '0 : regs_q[rt_idx];

  // Sequencer next state and datapath captures.
  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    rsv_d       = rsv_q;
    rtv_d       = rtv_q;
    dmem_addr_d = dmem_addr_q;
    wr_en       = 1'b0;
    wr_idx      = '0;
    wr_data     = result_in;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (fetch_go) begin
          ir_d    = instr_data;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        rsv_d   = rs_val;
        rtv_d   = rt_val;
        state_d = S_EXECUTE;
      end
      S_EXECUTE: state_d = S_WAIT;
      S_WAIT: begin
        // Address is loaded on entry so read data lands in WB.
        if (opcode == OP_LW) begin
          dmem_addr_d = result_in;
          state_d     = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        dmem_addr_d = result_in;
        state_d     = S_WB;
      end
      S_WB: begin
        if (!invalid_in) begin
          if (opcode == OP_ADDIU) begin
            wr_en  = 1'b1;
            wr_idx = rt_idx;
          end else if (opcode == OP_LW) begin
            wr_en   = 1'b1;
            wr_idx  = rt_idx;
            wr_data = dmem_data;
          end else if ((opcode == OP_RTYPE) && ((func == FN_ADDU) || (func == FN_SLT))) begin
            wr_en  = 1'b1;
            wr_idx = rd_idx;
          end else if (opcode == OP_JAL) begin
            wr_en  = 1'b1;
            wr_idx = RA_IDX;
          end
        end
        if (invalid_in || (pc_in >= MAX_PC_V)) begin
          state_d = S_HALT;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
    halted_d = (state_d == S_HALT);
  end

  // Register file update; writes to register 0 are dropped.
  always_comb begin
    regs_d = regs_q;
    if (wr_en && (wr_idx != '0)) begin
      regs_d[wr_idx] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ir_q        <= '0;
      rsv_q       <= '0;
      rtv_q       <= '0;
      dmem_addr_q <= '0;
      halted_q    <= 1'b0;
      regs_q      <= '0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      rsv_q       <= rsv_d;
      rtv_q       <= rtv_d;
      dmem_addr_q <= dmem_addr_d;
      halted_q    <= halted_d;
      regs_q      <= regs_d;
    end
  end

  assign instr_addr = pc_in;
  assign dmem_addr  = dmem_addr_q;
  assign state      = state_q;
  assign opcode     = ir_q[31:26];
  assign func       = ir_q[5:0];
  assign imm        = ir_q[15:0];
  assign jt         = ir_q[25:0];
  assign rsv        = rsv_q;
  assign rtv        = rtv_q;
  assign out_value  = (OUT_IDX == '0) ? '0 : regs_q[OUT_IDX];
  assign halted     = halted_q;

endmodule

// File: tb/tb_decode_wb.sv
// Directed self-checking bench for decode_wb (default parameters; step tests under SINGLE_STEP_EN).
module tb_decode_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  pc_in;
  logic [7:0]  result_in;
  logic        invalid_in;
  logic [7:0]  instr_addr;
  logic [31:0] instr_data;
  logic [7:0]  dmem_addr;
  logic [7:0]  dmem_data;
  logic [2:0]  state;
  logic [5:0]  opcode;
  logic [5:0]  func;
  logic [15:0] imm;
  logic [25:0] jt;
  logic [7:0]  rsv;
  logic [7:0]  rtv;
  logic [7:0]  out_value;
  logic        halted;
`ifdef SINGLE_STEP_EN
  logic        step = 1'b1;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  decode_wb dut (
    .clk        (clk),
    .rst        (rst),
`ifdef SINGLE_STEP_EN
    .step       (step),
`endif
    .pc_in      (pc_in),
    .result_in  (result_in),
    .invalid_in (invalid_in),
    .instr_addr (instr_addr),
    .instr_data (instr_data),
    .dmem_addr  (dmem_addr),
    .dmem_data  (dmem_data),
    .state      (state),
    .opcode     (opcode),
    .func       (func),
    .imm        (imm),
    .jt         (jt),
    .rsv        (rsv),
    .rtv        (rtv),
    .out_value  (out_value),
    .halted     (halted)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Drives one instruction from FETCH and records the states visited until FETCH or HALT.
  task automatic run_instr(input logic [31:0] ir, input logic [7:0] res, input logic [7:0] dm,
                           input logic [7:0] pc, input logic inv,
                           output logic [23:0] seq, output int n,
                           output logic [7:0] rsv_o, output logic [7:0] rtv_o,
                           output logic [7:0] dma_o);
    instr_data = ir;
    result_in  = res;
    dmem_data  = dm;
    pc_in      = pc;
    invalid_in = inv;
    seq   = '0;
    n     = 0;
    rsv_o = '0;
    rtv_o = '0;
    dma_o = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n++;
      seq = {seq[20:0], state};
      if (state == 3'd3) begin
        rsv_o = rsv;
        rtv_o = rtv;
      end
      if (state == 3'd5) dma_o = dmem_addr;
      if (state == 3'd1 || state == 3'd7) break;
    end
  endtask

  task automatic test_reset;
    for (int s = 0; s < 8; s++) begin
      instr_data = 32'h8C02_0000;
      result_in  = 8'h5A;
      dmem_data  = 8'h3C;
      pc_in      = 8'd14;
      invalid_in = 1'b0;
      do_reset();
      for (int k = 0; k < s; k++) tick();
      checks++;
      if (state !== 3'(s)) begin
        errors++; $display("FAIL reset_reach got=%0d exp=%0d", state, s);
      end
      if (s == 7) begin
        checks++;
        if (halted !== 1'b1 || out_value !== 8'h3C || dmem_addr !== 8'h5A) begin
          errors++;
          $display("FAIL pre_reset_halt halted=%0b out=%0h dmem_addr=%0h exp 1/3c/5a",
                   halted, out_value, dmem_addr);
        end
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (state !== 3'd0) begin
        errors++; $display("FAIL reset_state from=%0d got=%0d exp=0", s, state);
      end
      checks++;
      if (halted !== 1'b0 || out_value !== 8'h00) begin
        errors++; $display("FAIL reset_outs from=%0d halted=%0b out=%0h exp 0/0", s, halted, out_value);
      end
      checks++;
      if (opcode !== 6'h00 || rsv !== 8'h00 || rtv !== 8'h00 || dmem_addr !== 8'h00) begin
        errors++;
        $display("FAIL reset_regs from=%0d opcode=%0h rsv=%0h rtv=%0h dmem_addr=%0h exp all 0",
                 s, opcode, rsv, rtv, dmem_addr);
      end
    end
  endtask

  task automatic test_addiu;
    logic [23:0] seq;
    int n;
    logic [7:0] a, b, d;
    do_reset();
    tick();
    checks++;
    if (state !== 3'd1) begin
      errors++; $display("FAIL idle_to_fetch got=%0d exp=1", state);
    end
    pc_in = 8'h3B;
    #1;
    checks++;
    if (instr_addr !== 8'h3B) begin
      errors++; $display("FAIL instr_addr got=%0h exp=3b", instr_addr);
    end
    run_instr(32'h2402_0005, 8'd5, 8'h00, 8'd0, 1'b0, seq, n, a, b, d);
    checks++;
    if (seq !== 24'o23461 || n !== 5) begin
      errors++; $display("FAIL addiu_seq got=%0o n=%0d exp=23461 n=5", seq, n);
    end
    checks++;
    if (out_value !== 8'd5) begin
      errors++; $display("FAIL addiu_out got=%0h exp=5", out_value);
    end
    checks++;
    if (opcode !== 6'h09 || func !== 6'h05 || imm !== 16'h0005 || jt !== 26'h002_0005) begin
      errors++;
      $display("FAIL addiu_fields opcode=%0h func=%0h imm=%0h jt=%0h exp 9/5/5/20005",
               opcode, func, imm, jt);
    end
    // addu $3,$2,$2 reads the value just written by WB
    run_instr(32'h0042_1821, 8'h0A, 8'h00, 8'd1, 1'b0, seq, n, a, b, d);
    checks++;
    if (a !== 8'd5 || b !== 8'd5 || seq !== 24'o23461) begin
      errors++; $display("FAIL addu_read rsv=%0h rtv=%0h seq=%0o exp 5/5/23461", a, b, seq);
    end
    run_instr(32'h1062_0000, 8'h99, 8'h00, 8'd2, 1'b0, seq, n, a, b, d);
    checks++;
    if (a !== 8'h0A || b !== 8'd5 || out_value !== 8'd5) begin
      errors++; $display("FAIL beq_read rsv=%0h rtv=%0h out=%0h exp a/5/5", a, b, out_value);
    end
  endtask

  task automatic test_lw;
    logic [23:0] seq;
    int n;
    logic [7:0] a, b, d;
    run_instr(32'h8C02_0000, 8'h00, 8'h3C, 8'd3, 1'b0, seq, n, a, b, d);
    checks++;
    if (seq !== 24'o234561 || n !== 6) begin
      errors++; $display("FAIL lw_seq got=%0o n=%0d exp=234561 n=6", seq, n);
    end
    checks++;
    if (d !== 8'h00 || out_value !== 8'h3C) begin
      errors++; $display("FAIL lw_data dmem_addr=%0h out=%0h exp 0/3c", d, out_value);
    end
    run_instr(32'h8C02_0021, 8'h21, 8'h77, 8'd4, 1'b0, seq, n, a, b, d);
    checks++;
    if (d !== 8'h21 || out_value !== 8'h77) begin
      errors++; $display("FAIL lw2_data dmem_addr=%0h out=%0h exp 21/77", d, out_value);
    end
  endtask

  task automatic test_reg0_and_rd;
    logic [23:0] seq;
    int n;
    logic [7:0] a, b, d;
    run_instr(32'h0021_0021, 8'h55, 8'h00, 8'd5, 1'b0, seq, n, a, b, d);
    run_instr(32'h1002_0000, 8'h99, 8'h00, 8'd6, 1'b0, seq, n, a, b, d);
    checks++;
    if (a !== 8'h00 || b !== 8'h77 || out_value !== 8'h77) begin
      errors++; $display("FAIL reg0_write rsv=%0h rtv=%0h out=%0h exp 0/77/77", a, b, out_value);
    end
    run_instr(32'h0000_102A, 8'h01, 8'h00, 8'd7, 1'b0, seq, n, a, b, d);
    checks++;
    if (out_value !== 8'h01) begin
      errors++; $display("FAIL slt_rd got=%0h exp=1", out_value);
    end
  endtask

  task automatic test_jal_halt;
    logic [23:0] seq;
    int n;
    int bad;
    logic [7:0] a, b, d;
    run_instr(32'h0C00_0010, 8'd9, 8'h00, 8'd13, 1'b0, seq, n, a, b, d);
    checks++;
    if (seq !== 24'o23461 || opcode !== 6'h03 || jt !== 26'h10) begin
      errors++; $display("FAIL jal_pc13 seq=%0o opcode=%0h jt=%0h exp 23461/3/10", seq, opcode, jt);
    end
    run_instr(32'h03E0_0008, 8'h44, 8'h00, 8'd14, 1'b0, seq, n, a, b, d);
    checks++;
    if (a !== 8'd9) begin
      errors++; $display("FAIL jal_ra rsv=%0h exp=9", a);
    end
    checks++;
    if (seq !== 24'o23467 || halted !== 1'b1 || out_value !== 8'h01) begin
      errors++; $display("FAIL jr_halt seq=%0o halted=%0b out=%0h exp 23467/1/1", seq, halted, out_value);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (halted !== 1'b1 || state !== 3'd7) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL halt_hold bad_cycles=%0d exp=0", bad);
    end
  endtask

  task automatic test_invalid;
    logic [23:0] seq;
    int n;
    logic [7:0] a, b, d;
    do_reset();
    tick();
    run_instr(32'h2402_0066, 8'h66, 8'h00, 8'd0, 1'b1, seq, n, a, b, d);
    checks++;
    if (seq !== 24'o23467 || halted !== 1'b1 || out_value !== 8'h00) begin
      errors++;
      $display("FAIL invalid_wb seq=%0o halted=%0b out=%0h exp 23467/1/0", seq, halted, out_value);
    end
    invalid_in = 1'b0;
  endtask

`ifdef SINGLE_STEP_EN
  task automatic test_step;
    int bad;
    int n;
    step       = 1'b0;
    instr_data = 32'h2402_0012;
    result_in  = 8'h12;
    pc_in      = 8'd0;
    invalid_in = 1'b0;
    do_reset();
    tick();
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (state !== 3'd1) bad++;
    end
    checks++;
    if (bad !== 0 || out_value !== 8'h00) begin
      errors++; $display("FAIL step_stall bad_cycles=%0d out=%0h exp 0/0", bad, out_value);
    end
    step = 1'b1;
    tick();
    step = 1'b0;
    n = 1;
    checks++;
    if (state !== 3'd2) begin
      errors++; $display("FAIL step_go got=%0d exp=2", state);
    end
    for (int i = 0; i < 10 && state != 3'd1; i++) begin
      tick();
      n++;
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (state !== 3'd1) bad++;
    end
    checks++;
    if (n !== 5 || bad !== 0 || out_value !== 8'h12) begin
      errors++; $display("FAIL step_one n=%0d bad=%0d out=%0h exp 5/0/12", n, bad, out_value);
    end
    step = 1'b1;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst        = 1'b1;
    pc_in      = '0;
    result_in  = '0;
    invalid_in = 1'b0;
    instr_data = '0;
    dmem_data  = '0;
    tick();
    test_reset();
    test_addiu();
    test_lw();
    test_reg0_and_rd();
    test_jal_halt();
    test_invalid();
`ifdef SINGLE_STEP_EN
    test_step();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decode_wb.md
DECODE_WB -- requirements
Module: decode_wb

Interface
REQ-001 SHALL have parameter MAX_PC, default 14, meaning the PC value at or above which the core halts.
REQ-002 SHALL have parameter OUTPUT_REG, default 2, meaning the register index mirrored on out_value.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 Port list:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- pc_in  in  8  PC from execute stage
- result_in  in  8  result from execute stage
- invalid_in  in  1  instruction_invalid from execute stage
- instr_addr  out  8  instruction memory address, combinational, equal to pc_in
- instr_data  in  32  instruction word, asynchronous read, valid in the same cycle
- dmem_addr  out  8  data memory address
- dmem_data  in  8  data memory read value, valid the cycle after dmem_addr is driven
- state  out  3  sequencer state to execute stage
- opcode  out  6  instruction bits [31:26]
- func  out  6  instruction bits [5:0]
- imm  out  16  instruction bits [15:0]
- jt  out  26  instruction bits [25:0]
- rsv  out  8  register value of rs
- rtv  out  8  register value of rt
- out_value  out  8  register[OUTPUT_REG]
- halted  out  1  high in HALT

Function
REQ-005 SHALL hold a 32x8 register file; reads of register 0 SHALL return 0 and writes to register 0 SHALL be discarded.
REQ-006 SHALL sequence the states IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, WAIT=4, MEM=5, WB=6, HALT=7.
REQ-007 IDLE->FETCH SHALL be unconditional.
REQ-008 FETCH: SHALL latch instr_data into the instruction register, then go to DECODE.
REQ-009 DECODE: SHALL register rsv=reg[ir[25:21]] and rtv=reg[ir[20:16]], then go to EXECUTE.
REQ-010 opcode, func, imm and jt SHALL derive from the instruction register and SHALL be stable from DECODE through WB.
REQ-011 EXECUTE SHALL last exactly one cycle, then go to WAIT.
REQ-012 WAIT SHALL go to MEM if opcode=0x23, else to WB.
REQ-013 MEM: SHALL drive dmem_addr=result_in, then go to WB.
REQ-014 WB write target, at the closing edge of WB:
- addiu (0x09): reg[rt]<=result_in
- lw (0x23): reg[rt]<=dmem_data
- opcode 0, func 0x21 or 0x2a: reg[rd=ir[15:11]]<=result_in
- jal (0x03): reg[31]<=result_in
- beq, bne, jr, or invalid_in=1: no write
REQ-015 WB SHALL go to HALT if invalid_in=1 or pc_in>=MAX_PC, else to FETCH.
REQ-016 HALT SHALL hold with halted=1 until rst.
REQ-017 Latency SHALL be 5 cycles per non-lw instruction and 6 cycles per lw.
REQ-018 A write in WB SHALL be visible to the next instruction's DECODE read; no bypass is required.
REQ-019 Register arithmetic SHALL NOT occur in this block; all values SHALL be 8-bit and pass through unmodified.

Reset
REQ-020 rst SHALL have priority in any state, including mid-instruction.
REQ-021 On rst, the next state SHALL be IDLE, all 32 registers SHALL be cleared, and the instruction register, rsv, rtv, dmem_addr and halted SHALL be 0.

Configuration
REQ-022 With SINGLE_STEP_EN defined, a 1-bit input step SHALL be added, and FETCH SHALL stall until step=1 is sampled; one step pulse SHALL execute exactly one instruction.
REQ-023 Without SINGLE_STEP_EN, the step port SHALL NOT exist and FETCH SHALL never stall.

Verification
REQ-024 Reset in every state (0-7) -> IDLE next cycle, halted=0, out_value=0.
REQ-025 addiu $2,$0,5 with result_in=5 -> state sequence 1,2,3,4,6,1 and out_value=5 after WB.
REQ-026 lw $2,0($0) with result_in=0 and dmem_data=0x3C -> MEM visited, dmem_addr=0, out_value=0x3C.
REQ-027 addu $0,$1,$1 -> reg0 stays 0; beq -> no register change.
REQ-028 jal with result_in=9 -> reg[31]=9; pc_in=14 at WB -> HALT and halted=1 held 10 cycles.
REQ-029 invalid_in=1 at WB -> no write and HALT; with SINGLE_STEP_EN and step=0 -> FETCH holds for 20 cycles, and a one-cycle step pulse -> exactly one instruction completes.
